// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler
// Shares one serial shift-add multiplier between NREQ requesters. A
// round-robin arbiter picks a requester in IDLE, its operands are latched and
// held for the whole operation, the multiplier is started with a one-cycle
// pulse, and the product (or a watchdog error) is returned tagged with the
// requester ID. Only one operation is in flight at a time.
//
// Handshake semantics (both channels): a transfer happens on the rising clock
// edge where valid and ready are both 1. The request side is sampled only in
// IDLE, where req_ready is a one-hot grant. The response side holds rsp_valid,
// rsp_id, rsp_data and rsp_err stable from the cycle rsp_valid rises until the
// transfer edge, independent of rsp_ready.

module mac_rr_scheduler #(
    parameter int SIZE    = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 mul_start,
    output logic [SIZE-1:0]      mul_a,
    output logic [SIZE-1:0]      mul_b,
    input  logic                 mul_done,
    input  logic [2*SIZE-1:0]    mul_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*SIZE-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    // Watchdog only has to count up to TIMEOUT-1.
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [WDW-1:0]  wd_cnt;

    logic            any_valid;
    logic [IDW-1:0]  win;
    logic            accept;
    logic            done_hit;
    logic            timeout_hit;

    // Per-requester operand views of the flat input buses.
    logic [SIZE-1:0] a_arr [NREQ];
    logic [SIZE-1:0] b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign a_arr[g] = req_a[g*SIZE +: SIZE];
        assign b_arr[g] = req_b[g*SIZE +: SIZE];
    end

    // Round-robin winner: first valid requester scanning ptr, ptr+1, ... mod NREQ.
    always_comb begin
        logic [IDW:0] idx;
        any_valid = 1'b0;
        win       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!any_valid && req_valid[idx[IDW-1:0]]) begin
                any_valid = 1'b1;
                win       = idx[IDW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs. req_ready is also gated by reset_n so
    // the grant drops the instant reset is asserted.
    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        mul_start   = 1'b0;
        rsp_valid   = 1'b0;
        accept      = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid && reset_n) begin
                    req_ready[win] = 1'b1;
                    accept         = 1'b1;
                    state_nxt      = START;
                end
            end
            START: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A done arriving in the timeout cycle still delivers the product.
                if (mul_done) begin
                    done_hit  = 1'b1;
                    state_nxt = RESP;
                end else if (wd_cnt == WDW'(TIMEOUT-1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath: operand capture, pointer advance, watchdog, response capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            if (accept) begin
                mul_a  <= a_arr[win];
                mul_b  <= b_arr[win];
                rsp_id <= win;
                ptr    <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
            end
            if (state == START) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (done_hit) begin
                rsp_data <= mul_out;
                rsp_err  <= 1'b0;
            end else if (timeout_hit) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Bench for mac_rr_scheduler: table of single-operation vectors with
// hand-computed grants, products and latencies, plus hand-written sequences
// for reset, stray mul_done and reset in the middle of an operation.

module tb_mac_rr_scheduler;

    localparam int SIZE    = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 mul_start;
    logic [SIZE-1:0]      mul_a;
    logic [SIZE-1:0]      mul_b;
    logic                 mul_done;
    logic [2*SIZE-1:0]    mul_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [2*SIZE-1:0]    rsp_data;
    logic                 rsp_err;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;

    mac_rr_scheduler #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_out   (mul_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Multiplier model: latency mdl_lat cycles from the mul_start cycle to the
    // mul_done cycle (0 = never finishes). mul_out is garbage outside done.
    int          mdl_lat = 1;
    int          mdl_cnt;
    logic [15:0] mdl_prod;
    logic        force_done = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_cnt  <= 0;
            mdl_prod <= '0;
        end else if (mul_start) begin
            mdl_cnt  <= mdl_lat;
            mdl_prod <= 16'(mul_a) * 16'(mul_b);
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    assign mul_done = (mdl_cnt == 1) || force_done;
    assign mul_out  = mul_done ? mdl_prod : 16'hDEAD;

    typedef struct {
        logic [3:0]  rv;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hold;
        int          exp_id;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [31:0] p4(input int x0, input int x1, input int x2, input int x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] rv, input logic [31:0] a, input logic [31:0] b,
                                input int lat, input int hold, input int exp_id,
                                input logic [15:0] exp_data, input logic exp_err, input int exp_cyc);
        vec_t v;
        v.rv = rv; v.a = a; v.b = b; v.lat = lat; v.hold = hold;
        v.exp_id = exp_id; v.exp_data = exp_data; v.exp_err = exp_err; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Runs one operation. Entered at a negedge with the DUT in IDLE; leaves at
    // the negedge of the first IDLE cycle after the response handshake.
    task automatic apply(input vec_t v);
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] a0;
        logic [7:0] b0;
        int         cyc;
        int         extra_start;
        int         moved;
        ea = 8'(v.a >> (8*v.exp_id));
        eb = 8'(v.b >> (8*v.exp_id));
        req_valid = v.rv;
        req_a     = v.a;
        req_b     = v.b;
        mdl_lat   = v.lat;
        rsp_ready = (v.hold == 0);
        #1;
        check("grant", 32'(req_ready), 32'(1) << v.exp_id);
        @(negedge clk);
        check("mul_start", 32'(mul_start), 1);
        check("mul_a", 32'(mul_a), 32'(ea));
        check("mul_b", 32'(mul_b), 32'(eb));
        check("ready_in_start", 32'(req_ready), 0);
        a0 = mul_a;
        b0 = mul_b;
        cyc = 0;
        extra_start = 0;
        moved = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mul_start) extra_start++;
            if (!rsp_valid && (mul_a !== a0 || mul_b !== b0)) moved++;
        end while (!rsp_valid && cyc < 200);
        check("latency", 32'(cyc), 32'(v.exp_cyc));
        check("single_start", 32'(extra_start), 0);
        check("operands_held", 32'(moved), 0);
        check("rsp_id", 32'(rsp_id), 32'(v.exp_id));
        check("rsp_data", 32'(rsp_data), 32'(v.exp_data));
        check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_data", 32'(rsp_data), 32'(v.exp_data));
            check("bp_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("hs_valid", 32'(rsp_valid), 1);
        check("hs_no_grant", 32'(req_ready), 0);
        @(negedge clk);
        check("after_hs_valid", 32'(rsp_valid), 0);
        check("after_hs_busy", 32'(busy), 0);
    endtask

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 500000");
        $fatal(1, "global timeout");
    end

    initial begin
        int seen;
        // Vectors: ptr starts at 0; comments show ptr after each.
        tbl[0]  = mk(4'b1111, p4(1,2,3,4), p4(2,2,2,2), 3, 0, 0, 16'd2,  1'b0, 4);   // ptr 1
        tbl[1]  = mk(4'b1111, p4(1,2,3,4), p4(2,2,2,2), 3, 0, 1, 16'd4,  1'b0, 4);   // ptr 2
        tbl[2]  = mk(4'b1111, p4(1,2,3,4), p4(2,2,2,2), 3, 0, 2, 16'd6,  1'b0, 4);   // ptr 3
        tbl[3]  = mk(4'b1111, p4(1,2,3,4), p4(2,2,2,2), 3, 0, 3, 16'd8,  1'b0, 4);   // ptr 0
        tbl[4]  = mk(4'b1111, p4(1,2,3,4), p4(2,2,2,2), 3, 0, 0, 16'd2,  1'b0, 4);   // ptr 1
        tbl[5]  = mk(4'b0100, p4(0,0,5,0), p4(0,0,7,0), 2, 0, 2, 16'd35, 1'b0, 3);   // ptr 3
        tbl[6]  = mk(4'b0101, p4(9,0,12,0), p4(9,0,10,0), 4, 0, 0, 16'd81, 1'b0, 5); // ptr 1
        tbl[7]  = mk(4'b0101, p4(9,0,12,0), p4(9,0,10,0), 4, 0, 2, 16'd120, 1'b0, 5); // ptr 3
        tbl[8]  = mk(4'b0001, p4(13,0,0,0), p4(11,0,0,0), 10, 0, 0, 16'd143, 1'b0, 11); // ptr 1
        tbl[9]  = mk(4'b1000, p4(0,0,0,255), p4(0,0,0,255), 5, 5, 3, 16'd65025, 1'b0, 6); // ptr 0
        tbl[10] = mk(4'b0010, p4(0,200,0,0), p4(0,3,0,0), 1, 0, 1, 16'd600, 1'b0, 2); // ptr 2
        tbl[11] = mk(4'b0001, p4(7,0,0,0), p4(6,0,0,0), 0, 0, 0, 16'd0, 1'b1, 65);   // ptr 1
        tbl[12] = mk(4'b0010, p4(0,100,0,0), p4(0,50,0,0), 64, 0, 1, 16'd5000, 1'b0, 65); // ptr 2
        tbl[13] = mk(4'b1111, p4(3,3,3,3), p4(4,4,4,4), 63, 0, 2, 16'd12, 1'b0, 64); // ptr 3

        // Reset state.
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_start", 32'(mul_start), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i]);
        end

        // mul_done while IDLE is ignored.
        req_valid  = '0;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        check("idle_done_busy", 32'(busy), 0);
        check("idle_done_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        check("idle_done_valid2", 32'(rsp_valid), 0);

        // Reset in the 5th WAIT cycle; ptr is 3 before this grant.
        req_valid = 4'b0100;
        req_a     = p4(0,0,9,0);
        req_b     = p4(0,0,9,0);
        mdl_lat   = 0;
        rsp_ready = 1'b1;
        #1;
        check("mid_grant", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        check("mid_start", 32'(mul_start), 1);
        repeat (5) @(negedge clk);
        check("mid_busy_before", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_start", 32'(mul_start), 0);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_mul_a", 32'(mul_a), 0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        check("mid_no_rsp", 32'(seen), 0);
        // ptr is back at 0, so requester 0 wins over 1..3.
        apply(mk(4'b1111, p4(5,6,7,8), p4(3,3,3,3), 2, 0, 0, 16'd15, 1'b0, 3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
